ppm_frame_ctrl: RTL and testbench

// Frame-level controller behind the PPM decoder. Consumes SOF pulses (F_en) and decoded bytes (D_en/Dout).

---
 rtl/ppm_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ppm_frame_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ppm_frame_ctrl.sv
// Frame controller behind the PPM decoder: delimits frames from SOF/byte strobes,
// tags the last byte, and buffers {last,data} entries in a FIFO for a valid/ready consumer.
module ppm_frame_ctrl #(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 8,
  parameter int IDLE_TO = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sof_pulse,
  input  logic             i_byte_vld,
  input  logic [7:0]       i_byte_data,
  output logic             o_m_valid,
  output logic [7:0]       o_m_data,
  output logic             o_m_last,
  input  logic             i_m_ready,
  output logic             o_frame_done,
  output logic [LEN_W-1:0] o_frame_len,
  output logic             o_frame_err,
  output logic [1:0]       o_err_code,
  output logic             o_dec_clr,
  output logic             o_busy
);

  // state   | meaning
  // S_IDLE  | waiting for SOF, bytes ignored
  // S_ARMED | SOF seen, waiting for first byte
  // S_RECV  | receiving bytes, one held in the stage register
  // S_FLUSH | writing staged byte as last, reporting the frame
  // S_DROP  | aborted frame, discarding bytes until SOF
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RECV, S_FLUSH, S_DROP} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(IDLE_TO);

  state_t           r_state, w_state_nxt;
  logic             r_restart, w_restart_nxt;
  logic [7:0]       r_stage;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0]    r_tmr;
  logic             r_done, r_err;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_code;

  logic [8:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_fcnt;

  logic             w_sof, w_byte, w_evt, w_timing, w_tmo;
  logic             w_full, w_rd, w_wr, w_stage_ld, w_done, w_err;
  logic [8:0]       w_wr_data;
  logic [1:0]       w_err_code;

  assign w_sof    = i_en & i_sof_pulse;
  assign w_byte   = i_en & i_byte_vld;
  assign w_evt    = w_sof | w_byte;
  assign w_timing = (r_state == S_ARMED) || (r_state == S_RECV) || (r_state == S_DROP);
  assign w_tmo    = w_timing && !w_evt && (r_tmr == '0);
  assign w_full   = (r_fcnt == (AW+1)'(DEPTH));
  assign w_rd     = o_m_valid & i_m_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_restart_nxt = r_restart;
    w_cnt_nxt     = r_cnt;
    w_wr          = 1'b0;
    w_wr_data     = {1'b0, r_stage};
    w_stage_ld    = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
    w_err_code    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_sof) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end
      end
      S_ARMED: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_sof) begin
          w_cnt_nxt = '0;
        end else if (w_byte) begin
          w_stage_ld  = 1'b1;
          w_cnt_nxt   = LEN_W'(1);
          w_state_nxt = S_RECV;
        end else if (w_tmo) begin
          w_err       = 1'b1;
          w_err_code  = 2'b11;
          w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_sof) begin
          w_state_nxt   = S_FLUSH;
          w_restart_nxt = 1'b1;
        end else if (w_byte) begin
          if (r_cnt == LEN_W'(MAX_LEN)) begin
            w_err       = 1'b1;
            w_err_code  = 2'b10;
            w_state_nxt = S_DROP;
          end else if (w_full) begin
            w_err       = 1'b1;
            w_err_code  = 2'b01;
            w_state_nxt = S_DROP;
          end else begin
            w_wr       = 1'b1;
            w_stage_ld = 1'b1;
            w_cnt_nxt  = r_cnt + 1'b1;
          end
        end else if (w_tmo) begin
          w_state_nxt   = S_FLUSH;
          w_restart_nxt = 1'b0;
        end
      end
      S_FLUSH: begin
        w_restart_nxt = 1'b0;
        w_cnt_nxt     = '0;
        // A restarting frame already consumed its SOF, so it re-arms even after an overflow.
        if (w_full) begin
          w_err       = 1'b1;
          w_err_code  = 2'b01;
          w_state_nxt = r_restart ? S_ARMED : S_DROP;
        end else begin
          w_wr        = 1'b1;
          w_wr_data   = {1'b1, r_stage};
          w_done      = 1'b1;
          w_state_nxt = r_restart ? S_ARMED : S_IDLE;
        end
      end
      S_DROP: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_sof) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_restart <= 1'b0;
      r_cnt     <= '0;
      r_stage   <= '0;
      r_tmr     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_len     <= '0;
      r_code    <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_restart <= w_restart_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_stage_ld) r_stage <= i_byte_data;
      if (w_evt) r_tmr <= TW'(IDLE_TO - 1);
      else if (w_timing && (r_tmr != '0)) r_tmr <= r_tmr - 1'b1;
      r_done <= w_done;
      r_err  <= w_err;
      if (w_done || w_err) r_len <= r_cnt;
      if (w_err) r_code <= w_err_code;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !w_full) r_mem[r_wptr] <= w_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_wr && !w_full) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr && !w_full, w_rd})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign o_m_valid    = (r_fcnt != '0);
  assign o_m_last     = r_mem[r_rptr][8];
  assign o_m_data     = r_mem[r_rptr][7:0];
  assign o_frame_done = r_done;
  assign o_frame_len  = r_len;
  assign o_frame_err  = r_err;
  assign o_err_code   = r_code;
  assign o_dec_clr    = r_err;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// Scoreboard bench: instance A (DEPTH 16, MAX_LEN 4) covers framing, timeout, length and reset;
// instance B (DEPTH 4, MAX_LEN 32) covers FIFO overflow.
module tb_ppm_frame_ctrl;
  localparam int IDLE_TO = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_en, a_sof, a_bv, a_rdy, a_mv, a_ml, a_done, a_err, a_clr, a_busy;
  logic [7:0] a_bd, a_md, a_len;
  logic [1:0] a_code;
  logic       b_en, b_sof, b_bv, b_rdy, b_mv, b_ml, b_done, b_err, b_clr, b_busy;
  logic [7:0] b_bd, b_md, b_len;
  logic [1:0] b_code;

  ppm_frame_ctrl #(.DEPTH(16), .MAX_LEN(4), .LEN_W(8), .IDLE_TO(IDLE_TO)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_sof_pulse(a_sof), .i_byte_vld(a_bv),
    .i_byte_data(a_bd), .o_m_valid(a_mv), .o_m_data(a_md), .o_m_last(a_ml), .i_m_ready(a_rdy),
    .o_frame_done(a_done), .o_frame_len(a_len), .o_frame_err(a_err), .o_err_code(a_code),
    .o_dec_clr(a_clr), .o_busy(a_busy));

  ppm_frame_ctrl #(.DEPTH(4), .MAX_LEN(32), .LEN_W(8), .IDLE_TO(IDLE_TO)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_sof_pulse(b_sof), .i_byte_vld(b_bv),
    .i_byte_data(b_bd), .o_m_valid(b_mv), .o_m_data(b_md), .o_m_last(b_ml), .i_m_ready(b_rdy),
    .o_frame_done(b_done), .o_frame_len(b_len), .o_frame_err(b_err), .o_err_code(b_code),
    .o_dec_clr(b_clr), .o_busy(b_busy));

  // data entries are {last,data}; events are {dec_clr, err_code, frame_len}
  logic [8:0]  qd_a[$], qd_b[$];
  logic [10:0] qe_a[$], qe_b[$];
  int vectors = 0, miscompares = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] got);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected nothing", nm, got);
  endtask

  always @(negedge clk) begin : mon_a
    logic [10:0] eg;
    if (rst_n) begin
      if (a_mv && a_rdy) begin
        if (qd_a.size() == 0) unexpected("a_data", 32'({a_ml, a_md}));
        else cmp("a_data", 32'({a_ml, a_md}), 32'(qd_a.pop_front()));
      end
      if (a_done || a_err || a_clr) begin
        eg = {a_clr, a_err ? a_code : 2'b00, a_err ? 8'h00 : a_len};
        if (qe_a.size() == 0) unexpected("a_event", 32'(eg));
        else cmp("a_event", 32'(eg), 32'(qe_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [10:0] eg;
    if (rst_n) begin
      if (b_mv && b_rdy) begin
        if (qd_b.size() == 0) unexpected("b_data", 32'({b_ml, b_md}));
        else cmp("b_data", 32'({b_ml, b_md}), 32'(qd_b.pop_front()));
      end
      if (b_done || b_err || b_clr) begin
        eg = {b_clr, b_err ? b_code : 2'b00, b_err ? 8'h00 : b_len};
        if (qe_b.size() == 0) unexpected("b_event", 32'(eg));
        else cmp("b_event", 32'(eg), 32'(qe_b.pop_front()));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_byte(input logic [7:0] d);
    a_bv = 1'b1; a_bd = d; tick(); a_bv = 1'b0;
  endtask

  task automatic a_sof_p();
    a_sof = 1'b1; tick(); a_sof = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (qd_a.size() == 0 && qe_a.size() == 0 && qd_b.size() == 0 && qe_b.size() == 0) return;
      tick();
    end
    unexpected("drain_timeout", 32'(qd_a.size() + qe_a.size() + qd_b.size() + qe_b.size()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_en = 0; a_sof = 0; a_bv = 0; a_bd = 0; a_rdy = 0;
    b_en = 0; b_sof = 0; b_bv = 0; b_bd = 0; b_rdy = 0;
    tick(3);
    rst_n = 1'b1;
    tick();
    cmp("reset_a", 32'({a_mv, a_done, a_err, a_clr, a_busy, a_code, a_len}), 32'(0));
    cmp("reset_b", 32'({b_mv, b_done, b_err, b_clr, b_busy, b_code, b_len}), 32'(0));

    // 1: three bytes 20 cycles apart, closed by idle timeout
    a_en = 1; b_en = 1; a_rdy = 1;
    qd_a.push_back({1'b0, 8'hA5}); qd_a.push_back({1'b0, 8'h3C}); qd_a.push_back({1'b1, 8'h7E});
    qe_a.push_back({1'b0, 2'b00, 8'd3});
    a_sof_p();
    tick(3);
    a_byte(8'hA5); tick(19);
    cmp("t1_busy_mid", 32'(a_busy), 32'(1));
    a_byte(8'h3C); tick(19);
    a_byte(8'h7E);
    drain(200);
    cmp("t1_busy_end", 32'(a_busy), 32'(0));

    // 2: SOF with no bytes -> empty-frame error
    qe_a.push_back({1'b1, 2'b11, 8'h00});
    a_sof_p();
    tick(IDLE_TO - 5);
    cmp("t2_busy_mid", 32'(a_busy), 32'(1));
    drain(100);
    cmp("t2_busy_end", 32'(a_busy), 32'(0));
    cmp("t2_code_held", 32'(a_code), 32'(3));

    // 3: five bytes with MAX_LEN 4 -> three entries, too-long error, then DROP
    qd_a.push_back({1'b0, 8'h01}); qd_a.push_back({1'b0, 8'h02}); qd_a.push_back({1'b0, 8'h03});
    qe_a.push_back({1'b1, 2'b10, 8'h00});
    a_sof_p();
    for (int i = 1; i <= 5; i++) begin
      a_byte(8'(i)); tick();
    end
    drain(50);
    a_byte(8'h06); tick();
    a_byte(8'h07); tick(5);
    cmp("t3_busy_drop", 32'(a_busy), 32'(1));
    tick(IDLE_TO + 5);
    cmp("t3_busy_end", 32'(a_busy), 32'(0));
    cmp("t3_empty", 32'(a_mv), 32'(0));

    // 4: overflow on the depth-4 instance with consumer stalled
    b_rdy = 0;
    for (int i = 1; i <= 4; i++) qd_b.push_back({1'b0, 8'(8'hB0 + i)});
    qe_b.push_back({1'b1, 2'b01, 8'h00});
    b_sof = 1; tick(); b_sof = 0;
    for (int i = 1; i <= 7; i++) begin
      b_bv = 1; b_bd = 8'(8'hB0 + i); tick(); b_bv = 0; tick();
    end
    tick(2);
    cmp("t4_full_valid", 32'(b_mv), 32'(1));
    cmp("t4_code", 32'(b_code), 32'(1));
    b_rdy = 1;
    drain(50);
    tick(2);
    cmp("t4_drained", 32'(b_mv), 32'(0));

    // 5: SOF and byte in the same cycle while receiving
    qd_a.push_back({1'b0, 8'h11}); qd_a.push_back({1'b1, 8'h22}); qd_a.push_back({1'b1, 8'h44});
    qe_a.push_back({1'b0, 2'b00, 8'd2}); qe_a.push_back({1'b0, 2'b00, 8'd1});
    a_sof_p();
    a_byte(8'h11); tick(2);
    a_byte(8'h22); tick(2);
    a_sof = 1; a_bv = 1; a_bd = 8'h33; tick(); a_sof = 0; a_bv = 0;
    tick(3);
    cmp("t5_rearmed", 32'(a_busy), 32'(1));
    a_byte(8'h44);
    drain(200);

    // 6: reset mid-frame with three entries buffered
    a_rdy = 0;
    a_sof_p();
    for (int i = 1; i <= 4; i++) begin
      a_byte(8'(8'h60 + i)); tick();
    end
    tick(2);
    cmp("t6_pre_valid", 32'(a_mv), 32'(1));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cmp("t6_valid", 32'(a_mv), 32'(0));
    cmp("t6_busy", 32'(a_busy), 32'(0));
    cmp("t6_pulses", 32'({a_done, a_err, a_clr}), 32'(0));
    a_rdy = 1;
    tick(2 * IDLE_TO);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
